memaccess: RTL and testbench
============================

# memaccess

Data-memory access stage of the core pipeline. Sits directly downstream of the write stage: consumes its registered address/data, destination register and write enable, performs loads and stores against data memory through a req/ack handshake, and delivers the final register-file write. Stalls the upstream pipeline while a memory transaction is outstanding.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 16: cycles to wait for `memAck` before aborting (only with `MEMACCESS_TIMEOUT_EN`).

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inValid`  in  1  upstream presents an instruction this cycle.
- `code`  in  12  `[9:3]` opcode, `[2:0]` funct3, `[11:10]` reserved (ignored).
- `rd`  in  5  destination register.
- `writeEnabled`  in  1  instruction writes `rd`.
- `address`  in  32  effective address / ALU result.
- `storeData`  in  32  store data (rs2 value).
- `stall`  out  1  upstream must hold; high while a transaction is outstanding.
- `memReq`, `memWe`  out  1  memory request / write strobe.
- `memAddr`  out  32  word-aligned address (`address & ~3`).
- `memByteEn`  out  4  byte lanes.
- `memWdata`  out  32  lane-shifted store data.
- `memAck`  in  1  memory completes request this cycle.
- `memRdata`  in  32  read word, valid when `memAck`.
- `regWe`  out  1  register-file write enable (one-cycle pulse per instruction).
- `regAddr`  out  5  register-file address.
- `regData`  out  32  register-file data.
- `fault`  out  1  one-cycle pulse: misaligned access or timeout.

## Operation

- Opcode `0000011` = load, `0100011` = store, anything else = pass-through.
- States: IDLE, WAIT.
- IDLE, `inValid`=1:
  - pass-through: next edge `regWe`=`writeEnabled`, `regAddr`=`rd`, `regData`=`address`; stay IDLE.
  - load/store aligned: latch `rd`, funct3, `address[1:0]`, `writeEnabled`; drive `memReq`=1, `memWe`=store, `memAddr`, `memByteEn`, `memWdata`; go WAIT.
  - misaligned (half with `address[0]`=1, word with `address[1:0]`≠0, or funct3 not a legal width): no request, `fault`=1, `regWe`=0; stay IDLE.
- WAIT: memory outputs held constant. On `memAck`: go IDLE; loads write `regWe`=`writeEnabled`, `regAddr`, extended data; stores `regWe`=0.
- Byte lanes: byte `4'b0001<<a[1:0]`, half `4'b0011<<a[1:0]`, word `4'b1111`. Store data replicated to lanes (byte ×4, half ×2).
- Load extension from selected lane: funct3 0 LB sign, 1 LH sign, 2 LW, 4 LBU zero, 5 LHU zero. Store funct3 0/1/2 only.
- `regAddr`=0 still pulses `regWe`; register file ignores x0.

## Timing

- Reset: state IDLE; `stall`,`memReq`,`memWe`,`regWe`,`fault`=0; `memAddr`,`memByteEn`,`memWdata`,`regAddr`,`regData`=0.
- `stall` = (state==WAIT), combinational from state.
- Pass-through/fault latency: 1 cycle. Load/store: request asserted the edge after acceptance; `regWe` pulse the edge after the `memAck` cycle. Zero-wait memory (ack in first WAIT cycle): 2 cycles total.
- `memAck` in IDLE ignored. `inValid` in WAIT ignored (upstream is stalled).
- `regWe`, `fault` are single-cycle pulses, cleared next edge unless re-triggered.
- `reset` in WAIT: drop `memReq` immediately next edge, no `regWe`; late `memAck` ignored.

## Configuration

- `MEMACCESS_TIMEOUT_EN` defined: WAIT counter; if `memAck` absent for `TIMEOUT_CYCLES` consecutive WAIT cycles, drop `memReq`, pulse `fault`, `regWe`=0, return IDLE. Counter clears on entry to WAIT.
- Undefined: no counter; WAIT holds indefinitely until `memAck`.

## Test plan

- Pass-through: `code` opcode `0110011`, `address`=0x1234, `rd`=5, `writeEnabled`=1 -> next cycle `regWe`=1, `regAddr`=5, `regData`=0x1234, `memReq`=0.
- LB at 0x1003, `memRdata`=0x80FF_FF7F, ack after 2 WAIT cycles -> `memByteEn`=0x8, `memAddr`=0x1000, `stall` high 2 cycles, `regData`=0xFFFF_FF80.
- SH at 0x2002, `storeData`=0xABCD -> `memWe`=1, `memByteEn`=0xC, `memWdata`=0xABCD_ABCD, `regWe` stays 0.
- LW at 0x3001 -> `fault` pulse, `memReq`=0, `regWe`=0, `stall`=0.
- LHU at 0x4000, `memRdata`=0x0000_9ABC, reset asserted in WAIT -> outputs to reset values, subsequent `memAck` produces no `regWe`.
- With `MEMACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack -> `memReq` drops after 4 WAIT cycles, `fault`=1 for 1 cycle, state IDLE.

Source files
------------

// File: rtl/memaccess.sv
// Data-memory access stage: loads/stores over a req/ack port, final RF write.
// Optional WAIT watchdog enabled by defining MEMACCESS_TIMEOUT_EN.
module memaccess #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [11:0] code,
    input  logic [4:0]  rd,
    input  logic        writeEnabled,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        regWe,
    output logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic        fault
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      state, state_n;
    logic [4:0]  rd_q, rd_n;
    logic [2:0]  f3_q, f3_n;
    logic [1:0]  off_q, off_n;
    logic        we_q, we_n;
    logic        st_q, st_n;

    logic        mem_req_n, mem_we_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic [3:0]  mem_be_n;
    logic        reg_we_n, fault_n;
    logic [4:0]  reg_addr_n;
    logic [31:0] reg_data_n;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_load, is_store, is_mem;
    logic        width_ok, align_ok, access_ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted, load_val;
    logic        timeout_hit;
    logic        unused_code;

    assign unused_code = ^code[11:10];

`ifdef MEMACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_n;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign opcode   = code[9:3];
    assign f3       = code[2:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign stall    = (state == WAIT);

    // Width legality and natural alignment of the incoming access
    always_comb begin
        width_ok = 1'b0;
        if (is_load)
            width_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                    || (f3 == 3'd4) || (f3 == 3'd5);
        else if (is_store)
            width_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        unique case (f3[1:0])
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~address[0];
            2'd2:    align_ok = (address[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        access_ok = width_ok & align_ok;
    end

    // Byte lanes and lane-replicated store data
    always_comb begin
        unique case (f3[1:0])
            2'd0: begin
                be    = 4'b0001 << address[1:0];
                wdata = {4{storeData[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << address[1:0];
                wdata = {2{storeData[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = storeData;
            end
        endcase
    end

    assign shifted = memRdata >> {off_q, 3'b000};

    // Extend the selected lane of the returned word
    always_comb begin
        unique case (f3_q)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_val = {24'd0, shifted[7:0]};
            3'd5:    load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        rd_n        = rd_q;
        f3_n        = f3_q;
        off_n       = off_q;
        we_n        = we_q;
        st_n        = st_q;
        mem_req_n   = memReq;
        mem_we_n    = memWe;
        mem_addr_n  = memAddr;
        mem_be_n    = memByteEn;
        mem_wdata_n = memWdata;
        reg_we_n    = 1'b0;
        reg_addr_n  = regAddr;
        reg_data_n  = regData;
        fault_n     = 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
        cnt_n       = cnt_q;
`endif
        unique case (state)
            IDLE: begin
                if (inValid) begin
                    unique case (1'b1)
                        !is_mem: begin
                            reg_we_n   = writeEnabled;
                            reg_addr_n = rd;
                            reg_data_n = address;
                        end
                        is_mem && !access_ok: begin
                            fault_n = 1'b1;
                        end
                        is_mem && access_ok: begin
                            rd_n        = rd;
                            f3_n        = f3;
                            off_n       = address[1:0];
                            we_n        = writeEnabled;
                            st_n        = is_store;
                            mem_req_n   = 1'b1;
                            mem_we_n    = is_store;
                            mem_addr_n  = {address[31:2], 2'b00};
                            mem_be_n    = be;
                            mem_wdata_n = wdata;
                            state_n     = WAIT;
`ifdef MEMACCESS_TIMEOUT_EN
                            cnt_n       = '0;
`endif
                        end
                    endcase
                end
            end
            WAIT: begin
                if (memAck) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (!st_q) begin
                        reg_we_n   = we_q;
                        reg_addr_n = rd_q;
                        reg_data_n = load_val;
                    end
                end else if (timeout_hit) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    fault_n   = 1'b1;
                end else begin
`ifdef MEMACCESS_TIMEOUT_EN
                    cnt_n = cnt_q + 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            st_q      <= 1'b0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memByteEn <= '0;
            memWdata  <= '0;
            regWe     <= 1'b0;
            regAddr   <= '0;
            regData   <= '0;
            fault     <= 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            rd_q      <= rd_n;
            f3_q      <= f3_n;
            off_q     <= off_n;
            we_q      <= we_n;
            st_q      <= st_n;
            memReq    <= mem_req_n;
            memWe     <= mem_we_n;
            memAddr   <= mem_addr_n;
            memByteEn <= mem_be_n;
            memWdata  <= mem_wdata_n;
            regWe     <= reg_we_n;
            regAddr   <= reg_addr_n;
            regData   <= reg_data_n;
            fault     <= fault_n;
`ifdef MEMACCESS_TIMEOUT_EN
            cnt_q     <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_memaccess.sv
// Bench for memaccess: directed cases plus randomized transactions
// checked against a byte-level reference model.
module tb_memaccess;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [11:0] code;
    logic [4:0]  rd;
    logic        writeEnabled;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        regWe;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        fault;

    int errors = 0;
    int checks = 0;
    int txn = 0;

    always #5 clk = ~clk;

    memaccess #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .code(code),
        .rd(rd), .writeEnabled(writeEnabled), .address(address),
        .storeData(storeData), .stall(stall), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn),
        .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata),
        .regWe(regWe), .regAddr(regAddr), .regData(regData),
        .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d: observed=%h expected=%h",
                   tag, txn, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                       input logic [1:0] off);
        logic [3:0] b = '0;
        for (int i = 0; i < nbytes(f3); i++)
            if (int'(off) + i < 4) b[int'(off) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                           input logic [31:0] sd);
        logic [31:0] w;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] rdata);
        logic [63:0] v = '0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++)
            v = v | (64'(rdata[8*(int'(off) + i) +: 8]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n - 1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic bit m_legal(input int kind, input logic [2:0] f3,
                                  input logic [31:0] a);
        bit w;
        if (kind == 1) w = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else           w = (f3 inside {3'd0, 3'd1, 3'd2});
        return w && ((a % nbytes(f3)) == 0);
    endfunction

    // kind: 0 pass-through, 1 load, 2 store
    task automatic do_txn(input int kind, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r, input logic we,
                          input int waits, input logic [31:0] rdata);
        logic [6:0] op;
        logic [31:0] ea;
        logic [3:0] ebe;
        logic [31:0] ewd;
        txn++;
        if (kind == 1)      op = 7'b0000011;
        else if (kind == 2) op = 7'b0100011;
        else begin
            op = 7'($urandom);
            if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
        end
        inValid = 1'b1;
        code = {2'($urandom), op, f3};
        address = a;
        storeData = sd;
        rd = r;
        writeEnabled = we;
        memAck = 1'($urandom);
        memRdata = $urandom;
        step();
        if (kind == 0) begin
            chk("pt.regWe", 32'(regWe), 32'(we));
            chk("pt.regAddr", 32'(regAddr), 32'(r));
            chk("pt.regData", regData, a);
            chk("pt.memReq", 32'(memReq), 32'd0);
            chk("pt.stall", 32'(stall), 32'd0);
        end else if (!m_legal(kind, f3, a)) begin
            chk("mis.fault", 32'(fault), 32'd1);
            chk("mis.memReq", 32'(memReq), 32'd0);
            chk("mis.regWe", 32'(regWe), 32'd0);
            chk("mis.stall", 32'(stall), 32'd0);
        end else begin
            ea = a & ~32'd3;
            ebe = m_be(f3, a[1:0]);
            ewd = m_wdata(f3, sd);
            chk("req.stall", 32'(stall), 32'd1);
            chk("req.memReq", 32'(memReq), 32'd1);
            chk("req.memWe", 32'(memWe), 32'(kind == 2));
            chk("req.memAddr", memAddr, ea);
            chk("req.memByteEn", 32'(memByteEn), 32'(ebe));
            if (kind == 2) chk("req.memWdata", memWdata, ewd);
            for (int k = 0; k < waits; k++) begin
                inValid = 1'b1;
                code = 12'($urandom);
                address = $urandom;
                memAck = 1'b0;
                step();
                chk("wait.stall", 32'(stall), 32'd1);
                chk("wait.memReq", 32'(memReq), 32'd1);
                chk("wait.memAddr", memAddr, ea);
                chk("wait.memByteEn", 32'(memByteEn), 32'(ebe));
                chk("wait.regWe", 32'(regWe), 32'd0);
            end
            inValid = 1'b0;
            memAck = 1'b1;
            memRdata = rdata;
            step();
            chk("ack.stall", 32'(stall), 32'd0);
            chk("ack.memReq", 32'(memReq), 32'd0);
            chk("ack.regWe", 32'(regWe), 32'(kind == 1 && we));
            if (kind == 1 && we) begin
                chk("ack.regAddr", 32'(regAddr), 32'(r));
                chk("ack.regData", regData, m_load(f3, a[1:0], rdata));
            end
        end
        inValid = 1'b0;
        memAck = 1'b0;
        step();
        chk("end.regWe", 32'(regWe), 32'd0);
        chk("end.fault", 32'(fault), 32'd0);
        chk("end.stall", 32'(stall), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        inValid = 1'b0;
        code = '0;
        rd = '0;
        writeEnabled = 1'b0;
        address = '0;
        storeData = '0;
        memAck = 1'b0;
        memRdata = '0;
        step();
        step();
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.memReq", 32'(memReq), 32'd0);
        chk("rst.memWe", 32'(memWe), 32'd0);
        chk("rst.memAddr", memAddr, 32'd0);
        chk("rst.memByteEn", 32'(memByteEn), 32'd0);
        chk("rst.memWdata", memWdata, 32'd0);
        chk("rst.regWe", 32'(regWe), 32'd0);
        chk("rst.regAddr", 32'(regAddr), 32'd0);
        chk("rst.regData", regData, 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        reset = 1'b0;
        step();

        do_txn(0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        do_txn(1, 3'd0, 32'h1003, 32'h0, 5'd7, 1'b1, 1, 32'h80FF_FF7F);
        chk("lb.value", regData, 32'hFFFF_FF80);
        do_txn(2, 3'd1, 32'h2002, 32'hABCD, 5'd3, 1'b1, 0, 32'h0);
        do_txn(1, 3'd2, 32'h3001, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        do_txn(1, 3'd3, 32'h3000, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        do_txn(2, 3'd4, 32'h3000, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        do_txn(1, 3'd0, 32'h10, 32'h0, 5'd0, 1'b1, 0, 32'hFF);

        for (int i = 0; i < 120; i++) begin
            int kind;
            logic [2:0] f3;
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (kind == 1)
                f3 = (($urandom & 1) != 0) ? 3'($urandom_range(4, 5))
                                            : 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 2));
            do_txn(kind, f3, $urandom, $urandom, 5'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)), $urandom);
        end

        txn++;
        inValid = 1'b1;
        code = {2'b00, 7'b0000011, 3'd5};
        address = 32'h4000;
        rd = 5'd4;
        writeEnabled = 1'b1;
        step();
        chk("rw.memReq", 32'(memReq), 32'd1);
        inValid = 1'b0;
        reset = 1'b1;
        step();
        chk("rw.memReq0", 32'(memReq), 32'd0);
        chk("rw.stall0", 32'(stall), 32'd0);
        chk("rw.memAddr0", memAddr, 32'd0);
        chk("rw.regWe0", 32'(regWe), 32'd0);
        reset = 1'b0;
        memAck = 1'b1;
        memRdata = 32'h0000_9ABC;
        step();
        chk("rw.lateAckRegWe", 32'(regWe), 32'd0);
        chk("rw.lateAckStall", 32'(stall), 32'd0);
        memAck = 1'b0;
        step();
        chk("rw.regWeAfter", 32'(regWe), 32'd0);

`ifdef MEMACCESS_TIMEOUT_EN
        txn++;
        inValid = 1'b1;
        code = {2'b00, 7'b0000011, 3'd2};
        address = 32'h5000;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("to.memReqHeld", 32'(memReq), 32'd1);
            chk("to.stallHeld", 32'(stall), 32'd1);
        end
        step();
        chk("to.memReq", 32'(memReq), 32'd0);
        chk("to.fault", 32'(fault), 32'd1);
        chk("to.stall", 32'(stall), 32'd0);
        chk("to.regWe", 32'(regWe), 32'd0);
        step();
        chk("to.faultPulse", 32'(fault), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
